// File: rtl/seg7_frame_monitor.sv
// Receive-side monitor for the seven-segment bus: deglitches the 8-bit segment/dp
// pattern, decodes it back to a hex digit, and tracks frame hold times and counts.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no frame accepted since reset
// SETTLING | candidate differs from the accepted pattern, not yet stable
// LOCKED   | candidate equals the accepted pattern
module seg7_frame_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_W        = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_in,
  input  logic              clear,
  output logic              frame_valid,
  output logic [7:0]        pattern,
  output logic [3:0]        digit,
  output logic              is_digit,
  output logic              blank,
  output logic [HOLD_W-1:0] hold_cycles,
  output logic [15:0]       frame_count,
  output logic [7:0]        invalid_count
);

  typedef enum logic [1:0] {IDLE, SETTLING, LOCKED} state_t;

  localparam logic [7:0]        STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

  state_t            state_q, state_d;
  logic [7:0]        seg_q;
  logic [7:0]        cand_q, cand_d;
  logic [7:0]        stab_q, stab_d;
  logic              frame_valid_q, frame_valid_d;
  logic [7:0]        pattern_q, pattern_d;
  logic [3:0]        digit_q, digit_d;
  logic              is_digit_q, is_digit_d;
  logic              blank_q, blank_d;
  logic [HOLD_W-1:0] hold_ctr_q, hold_ctr_d;
  logic [HOLD_W-1:0] hold_cycles_q, hold_cycles_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [7:0]        invalid_count_q, invalid_count_d;

  logic              accept;
  logic [3:0]        dec_digit;
  logic              dec_hit;
  logic              dec_blank;

  always_comb begin
    dec_digit = 4'h0;
    dec_hit   = 1'b1;
    case (cand_d[6:0])
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: dec_hit = 1'b0;
    endcase
    dec_blank = (cand_d[6:0] == 7'h00);
  end

  always_comb begin
    cand_d          = cand_q;
    stab_d          = stab_q;
    state_d         = state_q;
    frame_valid_d   = 1'b0;
    pattern_d       = pattern_q;
    digit_d         = digit_q;
    is_digit_d      = is_digit_q;
    blank_d         = blank_q;
    hold_ctr_d      = (hold_ctr_q == HOLD_MAX) ? hold_ctr_q : hold_ctr_q + 1'b1;
    hold_cycles_d   = hold_cycles_q;
    frame_count_d   = clear ? 16'h0000 : frame_count_q;
    invalid_count_d = clear ? 8'h00 : invalid_count_q;

    if (seg_q != cand_q) begin
      cand_d = seg_q;
      stab_d = 8'd1;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end

    // Accept is judged on next-state values so outputs land with the pulse.
    accept = (stab_d == STAB_MAX) && ((state_q == IDLE) || (cand_d != pattern_q));

    if (accept) begin
      state_d       = LOCKED;
      frame_valid_d = 1'b1;
      pattern_d     = cand_d;
      digit_d       = dec_digit;
      is_digit_d    = dec_hit;
      blank_d       = dec_blank;
      hold_ctr_d    = '0;
      if (state_q == IDLE)
        hold_cycles_d = '0;
      else
        hold_cycles_d = (hold_ctr_q == HOLD_MAX) ? HOLD_MAX : hold_ctr_q + 1'b1;
      frame_count_d = frame_count_d + 16'd1;
      if (!dec_hit && !dec_blank && invalid_count_d != 8'hFF)
        invalid_count_d = invalid_count_d + 8'd1;
    end else if (state_q != IDLE) begin
      state_d = (cand_d != pattern_q) ? SETTLING : LOCKED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      seg_q           <= '0;
      cand_q          <= '0;
      stab_q          <= '0;
      frame_valid_q   <= 1'b0;
      pattern_q       <= '0;
      digit_q         <= '0;
      is_digit_q      <= 1'b0;
      blank_q         <= 1'b0;
      hold_ctr_q      <= '0;
      hold_cycles_q   <= '0;
      frame_count_q   <= '0;
      invalid_count_q <= '0;
    end else begin
      state_q         <= state_d;
      seg_q           <= seg_in;
      cand_q          <= cand_d;
      stab_q          <= stab_d;
      frame_valid_q   <= frame_valid_d;
      pattern_q       <= pattern_d;
      digit_q         <= digit_d;
      is_digit_q      <= is_digit_d;
      blank_q         <= blank_d;
      hold_ctr_q      <= hold_ctr_d;
      hold_cycles_q   <= hold_cycles_d;
      frame_count_q   <= frame_count_d;
      invalid_count_q <= invalid_count_d;
    end
  end

  assign frame_valid   = frame_valid_q;
  assign pattern       = pattern_q;
  assign digit         = digit_q;
  assign is_digit      = is_digit_q;
  assign blank         = blank_q;
  assign hold_cycles   = hold_cycles_q;
  assign frame_count   = frame_count_q;
  assign invalid_count = invalid_count_q;

endmodule
